// File: rtl/serial_add_sub_32_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: the FSM state encoding,
// the mode constants and the default operand width.
package serial_add_sub_32_pkg;

  localparam int   DEFAULT_WIDTH = 32;
  localparam logic MODE_ADD      = 1'b0;
  localparam logic MODE_SUB      = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_add_sub_32_full_adder.sv
// One-bit full adder. The serial datapath reuses this single cell once per bit.
module full_adder (
  input  logic cin,
  input  logic x,
  input  logic y,
  output logic s,
  output logic cout
);

  assign s    = x ^ y ^ cin;
  assign cout = (x & y) | (cin & (x ^ y));

endmodule

// File: rtl/serial_add_sub_32.sv
// Bit-serial WIDTH-bit adder/subtractor. It processes one bit per clock, LSB first,
// through a single full adder, with valid/ready handshakes on input and output.
//
// state   | meaning
// IDLE    | waiting for operands, in_ready high
// RUN     | one result bit per clock, WIDTH clocks in total
// DONE    | result held with out_valid until out_ready
module serial_add_sub_32
  import serial_add_sub_32_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic             cout,
  output logic             overflow,
  output logic             busy
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             fa_s, fa_c;
  logic             last_bit;

  full_adder u_bit_cell (
    .cin  (c_q),
    .x    (a_q[0]),
    .y    (b_q[0]),
    .s    (fa_s),
    .cout (fa_c)
  );

  assign last_bit = (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid)  state_d = ST_RUN;
      ST_RUN:  if (last_bit)  state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      ST_IDLE: in_ready = 1'b1;
      ST_RUN:  busy     = 1'b1;
      ST_DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  // Subtraction is x + ~y + 1: invert y once at accept and seed the carry with sub.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    r_d    = r_q;
    c_d    = c_q;
    cnt_d  = cnt_q;
    cout_d = cout_q;
    ovf_d  = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d   = x;
          b_d   = y ^ {WIDTH{sub}};
          c_d   = sub;
          cnt_d = '0;
        end
      end
      ST_RUN: begin
        r_d   = {fa_s, r_q[WIDTH-1:1]};
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = fa_c;
        cnt_d = cnt_q + 1'b1;
        if (last_bit) begin
          cout_d = fa_c;
          ovf_d  = c_q ^ fa_c;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      r_q    <= '0;
      c_q    <= 1'b0;
      cnt_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      r_q    <= r_d;
      c_q    <= c_d;
      cnt_q  <= cnt_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
    end
  end

  assign r        = r_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_add_sub_32.sv
// Scoreboard bench for serial_add_sub_32: operations push their expected result,
// and a monitor compares each result as out_valid rises.
module tb_serial_add_sub_32;
  import serial_add_sub_32_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x, y;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] r;
  logic         cout;
  logic         overflow;
  logic         busy;

  serial_add_sub_32 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r         (r),
    .cout      (cout),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] r;
    logic         c;
    logic         o;
    int           acc;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: compares each result in the first cycle that out_valid is high.
  initial begin : monitor
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1 && !prev) begin
        if (q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_result: got out_valid=1 want no pending result");
        end else begin
          e = q.pop_front();
          chk("r", r, e.r);
          chk("cout", W'(cout), W'(e.c));
          chk("overflow", W'(overflow), W'(e.o));
          chk("latency", W'(cyc - e.acc), W'(32));
        end
      end
      prev = (out_valid === 1'b1);
    end
  end

  task automatic issue(input logic [W-1:0] xv, input logic [W-1:0] yv, input logic s,
                       input logic [W-1:0] er, input logic ec, input logic eo);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      n_vec++;
      n_miss++;
      $display("FAIL issue_timeout: got in_ready=%b want 1", in_ready);
      return;
    end
    x = xv; y = yv; sub = s; in_valid = 1'b1;
    e.r = er; e.c = ec; e.o = eo; e.acc = cyc + 1;
    q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", W'(busy), W'(0));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, W'(in_ready), W'(1));
    chk({tag, "_out_valid"}, W'(out_valid), W'(0));
    chk({tag, "_r"}, r, '0);
    chk({tag, "_cout"}, W'(cout), W'(0));
    chk({tag, "_overflow"}, W'(overflow), W'(0));
    chk({tag, "_busy"}, W'(busy), W'(0));
  endtask

  initial begin : stim
    int n;
    rst_n = 1'b0; in_valid = 1'b0; x = '0; y = '0; sub = MODE_ADD; out_ready = 1'b1;
    #12;
    chk_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_no_valid", W'(out_valid), W'(0));
    end

    issue(32'h0000_0005, 32'h0000_0003, MODE_ADD, 32'h0000_0008, 1'b0, 1'b0);
    wait_idle();
    issue(32'h0000_0003, 32'h0000_0005, MODE_SUB, 32'hFFFF_FFFE, 1'b0, 1'b0);
    wait_idle();
    issue(32'h0000_0005, 32'h0000_0003, MODE_SUB, 32'h0000_0002, 1'b1, 1'b0);
    wait_idle();
    issue(32'h7FFF_FFFF, 32'h0000_0001, MODE_ADD, 32'h8000_0000, 1'b0, 1'b1);
    wait_idle();
    issue(32'h0000_0000, 32'h0000_0000, MODE_SUB, 32'h0000_0000, 1'b1, 1'b0);
    wait_idle();
    issue(32'h8000_0000, 32'h0000_0001, MODE_SUB, 32'h7FFF_FFFF, 1'b1, 1'b1);
    wait_idle();

    // Backpressure: result must hold and new requests must be ignored.
    out_ready = 1'b0;
    issue(32'h1234_5678, 32'h1111_1111, MODE_ADD, 32'h2345_6789, 1'b0, 1'b0);
    n = 0;
    while (out_valid !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("bp_wait_valid", W'(out_valid), W'(1));
    for (int i = 0; i < 10; i++) begin
      chk("bp_out_valid", W'(out_valid), W'(1));
      chk("bp_r", r, 32'h2345_6789);
      chk("bp_in_ready", W'(in_ready), W'(0));
      in_valid = i[0];
      x = 32'hDEAD_BEEF; y = 32'h0BAD_F00D; sub = MODE_SUB;
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_out_valid", W'(out_valid), W'(0));
    chk("bp_release_in_ready", W'(in_ready), W'(1));
    chk("bp_r_held", r, 32'h2345_6789);
    repeat (3) @(negedge clk);
    chk("bp_no_phantom_op", W'(busy), W'(0));

    // Reset asserted mid-RUN at bit 15.
    issue(32'hFFFF_FFFF, 32'h0000_0001, MODE_ADD, 32'h0000_0000, 1'b1, 1'b0);
    repeat (14) @(negedge clk);
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk_reset_outputs("midrun");
    @(negedge clk);
    rst_n = 1'b1;
    issue(32'h0000_0001, 32'h0000_0001, MODE_ADD, 32'h0000_0002, 1'b0, 1'b0);
    wait_idle();

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", W'(q.size()), W'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
